// File: rtl/decoder_stream_ctrl_pkg.sv
// Shared definitions for the decoder stream controller: bus widths,
// watchdog default and the controller state encoding.
package decoder_stream_ctrl_pkg;

  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = 128;
  localparam int DEFAULT_TIMEOUT = 200;

  // Controller states; the encoding is shared so other blocks can decode it
  typedef enum logic [2:0] {
    ST_FILL   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

endpackage

// File: rtl/decoder_stream_ctrl_if.sv
// Bundles the input stream, output stream and decoder handshake signals.
// The slave modport is the controller's view; master is the environment's.
interface decoder_stream_ctrl_if;
  import decoder_stream_ctrl_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [WORD_W-1:0]  in_data;
  logic [BLOCK_W-1:0] key_in;

  logic               out_valid;
  logic               out_ready;
  logic [WORD_W-1:0]  out_data;

  logic               dec_enable;
  logic [BLOCK_W-1:0] dec_data;
  logic [BLOCK_W-1:0] dec_key;
  logic [BLOCK_W-1:0] dec_result;
  logic               dec_done;

  modport slave (
    input  in_valid, in_data, key_in, out_ready, dec_result, dec_done,
    output in_ready, out_valid, out_data, dec_enable, dec_data, dec_key
  );

  modport master (
    output in_valid, in_data, key_in, out_ready, dec_result, dec_done,
    input  in_ready, out_valid, out_data, dec_enable, dec_data, dec_key
  );

endinterface

// File: rtl/decoder_stream_ctrl.sv
// Stream front/back end for the 128-bit block decoder: packs 32-bit words
// into a block, runs the decoder, and streams the result back out as words.
// A watchdog parks the controller in an error state if done never arrives.
module decoder_stream_ctrl
  import decoder_stream_ctrl_pkg::*;
#(
  parameter int WORDS   = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                 clock,
  input  logic                 reset,
  decoder_stream_ctrl_if.slave bus,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int CNT_W  = $clog2(WORDS);
  localparam int WDOG_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(WORDS - 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  state_t                       state;
  logic [CNT_W-1:0]             cnt;
  logic [WORDS-1:0][WORD_W-1:0] block_q;
  logic [WORDS-1:0][WORD_W-1:0] result_q;
  logic [BLOCK_W-1:0]           key_q;
  logic [WDOG_W-1:0]            wdog;

  // Handshake strobes decode straight from the state register so that
  // in_ready never depends on in_valid and out_valid never on out_ready.
  // dec_enable drops with done in RUN so the decoder freezes on that edge
  // instead of reloading, and it is forced low while reset is held.
  assign bus.in_ready   = (state == ST_FILL);
  assign bus.out_valid  = (state == ST_DRAIN);
  assign bus.out_data   = result_q[cnt];
  assign bus.dec_data   = block_q;
  assign bus.dec_key    = key_q;
  assign bus.dec_enable = !reset &&
                          ((state == ST_LAUNCH) ||
                           ((state == ST_RUN) && !bus.dec_done));
  assign busy           = (state != ST_FILL);

  // Main controller: word assembly, decoder launch/wait with watchdog,
  // result serialisation, and the sticky error trap.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_FILL;
      cnt         <= '0;
      block_q     <= '0;
      result_q    <= '0;
      key_q       <= '0;
      wdog        <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        ST_FILL: begin
          if (bus.in_valid) begin
            block_q[cnt] <= bus.in_data;
            if (cnt == LAST_WORD) begin
              key_q <= bus.key_in;
              cnt   <= '0;
              state <= ST_LAUNCH;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        // Done may still be high from the previous block here; the
        // decoder clears it as it loads, so it is not looked at.
        ST_LAUNCH: begin
          wdog  <= '0;
          state <= ST_RUN;
        end

        ST_RUN: begin
          if (bus.dec_done) begin
            result_q <= bus.dec_result;
            cnt      <= '0;
            state    <= ST_DRAIN;
          end else if (wdog == WDOG_LAST) begin
            timeout_err <= 1'b1;
            state       <= ST_ERR;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end

        ST_DRAIN: begin
          if (bus.out_ready) begin
            if (cnt == LAST_WORD) begin
              cnt   <= '0;
              state <= ST_FILL;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        // Only reset leaves the error trap.
        ST_ERR: begin
          state <= ST_ERR;
        end

        default: begin
          state <= ST_FILL;
        end
      endcase
    end
  end

endmodule
